// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads on the instruction bus and
// buffers returned words with their addresses in a small first-word-fall-through FIFO.
module ifu_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        stall_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] INST_NOP = 32'h0000_0001;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_reqRdPtr;
    logic [PW-1:0] r_reqWrPtr;
    logic [31:0]   r_fifoData [DEPTH];
    logic [31:0]   r_fifoAddr [DEPTH];
    logic [31:0]   r_reqAddr  [DEPTH];

    logic          w_req;
    logic          w_issue;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_inUse;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // In-flight plus buffered words are capped at DEPTH, so the FIFO can never overflow.
    assign w_inUse = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req   = rst && !jump_flag_i && (hold_flag_i == 3'd0) && (w_inUse < (CW+1)'(DEPTH));
    assign w_issue = w_req && ibus_gnt_i;
    assign w_rsp   = ibus_rvalid_i && (r_outstanding != '0);
    assign w_drop  = w_rsp && (r_discard != '0);
    assign w_push  = w_rsp && !w_drop && !jump_flag_i;
    assign w_pop   = (r_count != '0) && !stall_flag_i && (hold_flag_i < 3'd2) && !jump_flag_i;

    assign ibus_req_o  = w_req;
    assign ibus_addr_o = r_pc;
    assign inst_o      = (r_count != '0) ? r_fifoData[r_rdPtr] : INST_NOP;
    assign inst_addr_o = (r_count != '0) ? r_fifoAddr[r_rdPtr] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_reqRdPtr    <= '0;
            r_reqWrPtr    <= '0;
        end else begin
            if (jump_flag_i) begin
                r_pc <= jump_addr_i & ~32'h3;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp);
            // Everything still in flight at a redirect belongs to the old stream.
            if (jump_flag_i) begin
                r_discard <= r_outstanding - CW'(w_rsp);
            end else if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_issue) begin
                r_reqWrPtr <= nextPtr(r_reqWrPtr);
            end
            if (w_rsp) begin
                r_reqRdPtr <= nextPtr(r_reqRdPtr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else if (jump_flag_i) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_reqAddr[r_reqWrPtr] <= r_pc;
        end
        if (w_push) begin
            r_fifoData[r_wrPtr] <= ibus_rdata_i;
            r_fifoAddr[r_wrPtr] <= r_reqAddr[r_reqRdPtr];
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: per-cycle vectors of bus/pipeline inputs with
// hand-derived expected request and instruction outputs, plus a mid-stream reset.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0001;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic [2:0]  hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInst;
        logic [31:0] expIAddr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        jumpFlag;
    logic [31:0] jumpAddr;
    logic [2:0]  holdFlag;
    logic        stallFlag;
    logic        ibusReq;
    logic [31:0] ibusAddr;
    logic        ibusGnt;
    logic        ibusRvalid;
    logic [31:0] ibusRdata;
    logic [31:0] inst;
    logic [31:0] instAddr;

    int   checks = 0;
    int   errors = 0;
    vec_t rows[$];

    ifu_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jumpFlag),
        .jump_addr_i  (jumpAddr),
        .hold_flag_i  (holdFlag),
        .stall_flag_i (stallFlag),
        .ibus_req_o   (ibusReq),
        .ibus_addr_o  (ibusAddr),
        .ibus_gnt_i   (ibusGnt),
        .ibus_rvalid_i(ibusRvalid),
        .ibus_rdata_i (ibusRdata),
        .inst_o       (inst),
        .inst_addr_o  (instAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addRow(input logic gnt, input logic rv, input logic [31:0] rdA,
                          input logic stall, input logic [2:0] hold,
                          input logic jmp, input logic [31:0] jaddr,
                          input logic eReq, input logic [31:0] eAddr,
                          input logic eHas, input logic [31:0] eIAddr);
        vec_t v;
        v.gnt      = gnt;
        v.rvalid   = rv;
        v.rdata    = rv ? d(rdA) : 32'hDEAD_BEEF;
        v.stall    = stall;
        v.hold     = hold;
        v.jump     = jmp;
        v.jaddr    = jaddr;
        v.expReq   = eReq;
        v.expAddr  = eAddr;
        v.expInst  = eHas ? d(eIAddr) : NOP;
        v.expIAddr = eHas ? eIAddr : 32'h0;
        rows.push_back(v);
    endtask

    // Inputs change on the falling edge and outputs are sampled 1ns later.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        ibusGnt    = v.gnt;
        ibusRvalid = v.rvalid;
        ibusRdata  = v.rdata;
        stallFlag  = v.stall;
        holdFlag   = v.hold;
        jumpFlag   = v.jump;
        jumpAddr   = v.jaddr;
        #1;
    endtask

    task automatic runTable(input string tag);
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            checkOutput($sformatf("%s[%0d].req", tag, i), {31'b0, ibusReq}, {31'b0, rows[i].expReq});
            checkOutput($sformatf("%s[%0d].addr", tag, i), ibusAddr, rows[i].expAddr);
            checkOutput($sformatf("%s[%0d].inst", tag, i), inst, rows[i].expInst);
            checkOutput($sformatf("%s[%0d].iaddr", tag, i), instAddr, rows[i].expIAddr);
        end
        rows.delete();
    endtask

    initial begin
        rst        = 1'b0;
        jumpFlag   = 1'b0;
        jumpAddr   = 32'h0;
        holdFlag   = 3'd0;
        stallFlag  = 1'b0;
        ibusGnt    = 1'b0;
        ibusRvalid = 1'b0;
        ibusRdata  = 32'h0;
        #2;
        checkOutput("rst.req", {31'b0, ibusReq}, 32'h0);
        checkOutput("rst.addr", ibusAddr, 32'h0);
        checkOutput("rst.inst", inst, NOP);
        checkOutput("rst.iaddr", instAddr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming, stall, jump with two outstanding, hold levels, withheld grant.
        addRow(1,0,0,          0,0,0,0,        1,32'h0,   0,0);
        addRow(1,1,32'h0,      0,0,0,0,        1,32'h4,   0,0);
        addRow(1,1,32'h4,      0,0,0,0,        0,32'h8,   1,32'h0);
        addRow(1,0,0,          0,0,0,0,        1,32'h8,   1,32'h4);
        addRow(1,1,32'h8,      0,0,0,0,        1,32'hC,   0,0);
        addRow(1,1,32'hC,      1,0,0,0,        0,32'h10,  1,32'h8);
        for (int k = 0; k < 4; k++)
            addRow(1,0,0,      1,0,0,0,        0,32'h10,  1,32'h8);
        addRow(1,0,0,          0,0,0,0,        0,32'h10,  1,32'h8);
        addRow(1,0,0,          0,0,0,0,        1,32'h10,  1,32'hC);
        addRow(1,0,0,          0,0,0,0,        1,32'h14,  0,0);
        addRow(1,0,0,          0,0,1,32'h103,  0,32'h18,  0,0);
        addRow(1,1,32'h10,     0,0,0,0,        0,32'h100, 0,0);
        addRow(1,1,32'h14,     0,0,0,0,        1,32'h100, 0,0);
        addRow(1,1,32'h100,    0,0,0,0,        1,32'h104, 0,0);
        addRow(1,1,32'h104,    0,0,0,0,        0,32'h108, 1,32'h100);
        addRow(1,0,0,          0,1,0,0,        0,32'h108, 1,32'h104);
        addRow(1,0,0,          0,1,0,0,        0,32'h108, 0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'h108, 0,0);
        addRow(1,1,32'h108,    0,0,0,0,        1,32'h10C, 0,0);
        addRow(1,1,32'h10C,    0,2,0,0,        0,32'h110, 1,32'h108);
        addRow(1,0,0,          0,2,0,0,        0,32'h110, 1,32'h108);
        addRow(1,0,0,          0,0,0,0,        0,32'h110, 1,32'h108);
        addRow(0,0,0,          0,0,0,0,        1,32'h110, 1,32'h10C);
        addRow(0,0,0,          0,0,0,0,        1,32'h110, 0,0);
        addRow(0,0,0,          0,0,0,0,        1,32'h110, 0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'h110, 0,0);
        addRow(1,1,32'h110,    0,0,0,0,        1,32'h114, 0,0);
        runTable("t1");

        // Reset with one word buffered and one read (0x114) still in flight.
        @(negedge clk);
        ibusGnt    = 1'b0;
        ibusRvalid = 1'b0;
        #1;
        checkOutput("prerst.inst", inst, d(32'h110));
        checkOutput("prerst.iaddr", instAddr, 32'h110);
        checkOutput("prerst.req", {31'b0, ibusReq}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst.inst", inst, NOP);
        checkOutput("midrst.iaddr", instAddr, 32'h0);
        checkOutput("midrst.req", {31'b0, ibusReq}, 32'h0);
        checkOutput("midrst.addr", ibusAddr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Stale response ignored, restart at 0, PC wrap, jump coinciding with a response.
        addRow(0,1,32'h114,    0,0,0,0,        1,32'h0,   0,0);
        addRow(0,0,0,          0,0,0,0,        1,32'h0,   0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'h0,   0,0);
        addRow(0,1,32'h0,      0,0,0,0,        1,32'h4,   0,0);
        addRow(0,0,0,          0,0,0,0,        1,32'h4,   1,32'h0);
        addRow(1,0,0,          0,0,1,32'hFFFF_FFFF, 0,32'h4, 0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'hFFFF_FFFC, 0,0);
        addRow(1,1,32'hFFFF_FFFC, 0,0,0,0,     1,32'h0,   0,0);
        addRow(0,1,32'h0,      0,0,0,0,        0,32'h4,   1,32'hFFFF_FFFC);
        addRow(0,0,0,          0,0,0,0,        1,32'h4,   1,32'h0);
        addRow(0,0,0,          0,0,0,0,        1,32'h4,   0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'h4,   0,0);
        addRow(1,0,0,          0,0,0,0,        1,32'h8,   0,0);
        addRow(1,1,32'h4,      0,0,1,32'h200,  0,32'hC,   0,0);
        addRow(1,1,32'h8,      0,0,0,0,        1,32'h200, 0,0);
        addRow(0,1,32'h200,    0,0,0,0,        1,32'h204, 0,0);
        addRow(0,0,0,          1,0,0,0,        1,32'h204, 1,32'h200);
        addRow(0,0,0,          0,0,1,32'h300,  0,32'h204, 1,32'h200);
        addRow(0,0,0,          0,0,0,0,        1,32'h300, 0,0);
        runTable("t2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
